// File: rtl/struct_record_packer.sv
// Field-write accumulator: gathers x/y/z field commands into a shadow record
// and emits the packed record through a one-entry valid/ready output register.
module struct_record_packer #(
   parameter int X_W   = 32,
   parameter int Z_W   = 4,
   parameter int CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [3:0]           in_sel,
   input  logic [X_W-1:0]       in_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [X_W+Z_W:0]     out_rec,
   output logic [2:0]           out_mask,
   output logic [CNT_W-1:0]     rec_count,
   output logic                 err,
   output logic [1:0]           dbg_state
);

   localparam int REC_W = X_W + 1 + Z_W;

   localparam logic [3:0] OP_X      = 4'd0;
   localparam logic [3:0] OP_Y      = 4'd1;
   localparam logic [3:0] OP_Z      = 4'd2;
   localparam logic [3:0] OP_COMMIT = 4'd3;
   localparam logic [3:0] OP_CLEAR  = 4'd4;

   typedef enum logic [1:0] {
      ST_EMPTY   = 2'd0,
      ST_PARTIAL = 2'd1,
      ST_HOLD    = 2'd2
   } state_t;

   // Handshake: a transfer happens on a rising edge where valid & ready are
   // both high; ready may depend combinationally on the downstream ready.

   logic [X_W-1:0]   x_q, x_d;
   logic             y_q, y_d;
   logic [Z_W-1:0]   z_q, z_d;
   logic [2:0]       mask_q, mask_d;
   logic             out_valid_q, out_valid_d;
   logic [REC_W-1:0] out_rec_q, out_rec_d;
   logic [2:0]       out_mask_q, out_mask_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;
   logic             accept, deliver;
   state_t           state;

   assign in_ready  = !rst && (!out_valid_q || out_ready);
   assign accept    = in_valid && in_ready;
   assign deliver   = out_valid_q && out_ready;

   assign out_valid = out_valid_q;
   assign out_rec   = out_rec_q;
   assign out_mask  = out_mask_q;
   assign rec_count = cnt_q;
   assign err       = err_q;
   assign dbg_state = state;

   // HOLD reflects the output register; EMPTY/PARTIAL reflect the dirty mask.
   always_comb begin
      state = ST_EMPTY;
      if (out_valid_q)
         state = ST_HOLD;
      else if (mask_q != 3'b000)
         state = ST_PARTIAL;
   end

   always_comb begin
      x_d         = x_q;
      y_d         = y_q;
      z_d         = z_q;
      mask_d      = mask_q;
      out_valid_d = out_valid_q;
      out_rec_d   = out_rec_q;
      out_mask_d  = out_mask_q;
      cnt_d       = cnt_q;
      err_d       = 1'b0;

      if (deliver) begin
         cnt_d       = cnt_q + CNT_W'(1);
         out_valid_d = 1'b0;
      end

      if (accept) begin
         case (in_sel)
            OP_X: begin
               x_d       = in_data;
               mask_d[2] = 1'b1;
            end
            OP_Y: begin
               y_d       = in_data[0];
               mask_d[1] = 1'b1;
            end
            OP_Z: begin
               z_d       = in_data[Z_W-1:0];
               mask_d[0] = 1'b1;
            end
            OP_COMMIT: begin
               // Shadow values stay sticky; only the dirty mask is consumed.
               if (mask_q == 3'b000) begin
                  err_d = 1'b1;
               end else begin
                  out_rec_d   = {x_q, y_q, z_q};
                  out_mask_d  = mask_q;
                  out_valid_d = 1'b1;
                  mask_d      = 3'b000;
               end
            end
            OP_CLEAR: begin
               x_d    = '0;
               y_d    = 1'b0;
               z_d    = '0;
               mask_d = 3'b000;
            end
            default: err_d = 1'b1;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         x_q         <= '0;
         y_q         <= 1'b0;
         z_q         <= '0;
         mask_q      <= 3'b000;
         out_valid_q <= 1'b0;
         out_rec_q   <= '0;
         out_mask_q  <= 3'b000;
         cnt_q       <= '0;
         err_q       <= 1'b0;
      end else begin
         x_q         <= x_d;
         y_q         <= y_d;
         z_q         <= z_d;
         mask_q      <= mask_d;
         out_valid_q <= out_valid_d;
         out_rec_q   <= out_rec_d;
         out_mask_q  <= out_mask_d;
         cnt_q       <= cnt_d;
         err_q       <= err_d;
      end
   end

endmodule

// File: tb/tb_struct_record_packer.sv
// Bench for struct_record_packer: directed scenarios plus random traffic,
// all checked every cycle against a queue-based record model.
module tb_struct_record_packer;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  in_sel;
   logic [31:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [36:0] out_rec;
   logic [2:0]  out_mask;
   logic [7:0]  rec_count;
   logic        err;
   logic [1:0]  dbg_state;

   int checks = 0;
   int errors = 0;
   int cycle  = 0;
   bit chk_en = 1'b0;

   // clock / reset
   always #5 clk = ~clk;
   always @(posedge clk) cycle++;

   struct_record_packer dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_rec(out_rec),
      .out_mask(out_mask), .rec_count(rec_count), .err(err), .dbg_state(dbg_state)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
      end
   endtask

   // behavioural model: shadow fields plus a queue of pending {mask, record}
   logic [39:0] exp_q[$];
   logic [31:0] m_x;
   logic        m_y;
   logic [3:0]  m_z;
   logic [2:0]  m_mask;
   logic [7:0]  m_count;
   logic        m_err;

   always @(posedge clk) begin
      bit rdy;
      if (rst) begin
         exp_q.delete();
         m_x = 0; m_y = 0; m_z = 0; m_mask = 0; m_count = 0; m_err = 0;
      end else begin
         rdy   = (exp_q.size() == 0) || out_ready;
         m_err = 1'b0;
         if (exp_q.size() != 0 && out_ready) begin
            void'(exp_q.pop_front());
            m_count = m_count + 8'd1;
         end
         if (in_valid && rdy) begin
            case (in_sel)
               4'd0: begin m_x = in_data;      m_mask = m_mask | 3'b100; end
               4'd1: begin m_y = in_data[0];   m_mask = m_mask | 3'b010; end
               4'd2: begin m_z = in_data[3:0]; m_mask = m_mask | 3'b001; end
               4'd3: begin
                  if (m_mask == 0) m_err = 1'b1;
                  else begin
                     exp_q.push_back({m_mask, m_x, m_y, m_z});
                     m_mask = 0;
                  end
               end
               4'd4: begin m_x = 0; m_y = 0; m_z = 0; m_mask = 0; end
               default: m_err = 1'b1;
            endcase
         end
      end
   end

   // scoreboard compare, mid-cycle
   always @(negedge clk) begin
      if (chk_en) begin
         chk("in_ready", 64'(in_ready), 64'(!rst && (exp_q.size() == 0 || out_ready)));
         chk("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
         chk("err", 64'(err), 64'(m_err));
         chk("rec_count", 64'(rec_count), 64'(m_count));
         if (exp_q.size() != 0) begin
            chk("out_rec", 64'(out_rec), 64'(exp_q[0][36:0]));
            chk("out_mask", 64'(out_mask), 64'(exp_q[0][39:37]));
         end
      end
   end

   // driver tasks; called and return at posedge + 1
   task automatic send(input logic [3:0] s, input logic [31:0] d);
      int  n = 0;
      bit  ok = 1'b0;
      in_valid = 1'b1; in_sel = s; in_data = d;
      do begin
         @(negedge clk); ok = in_ready;
         @(posedge clk); #1; n++;
      end while (!ok && n < 200);
      if (!ok) begin
         errors++;
         $display("FAIL send_timeout: sel %0d not accepted within %0d cycles", s, n);
      end
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   initial begin
      int t0;
      rst = 1'b1; in_valid = 1'b0; in_sel = 0; in_data = 0; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk_en = 1'b1;
      @(negedge clk);
      chk("in_ready_in_rst", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_rec", 64'(out_rec), 64'd0);
      chk("rst_out_mask", 64'(out_mask), 64'd0);
      chk("rst_rec_count", 64'(rec_count), 64'd0);
      chk("rst_err", 64'(err), 64'd0);

      // 1: single x write then commit
      send(0, 32'd23); send(3, 0);
      chk("t1_valid", 64'(out_valid), 64'd1);
      chk("t1_rec", 64'(out_rec), 64'({32'd23, 1'b0, 4'h0}));
      chk("t1_mask", 64'(out_mask), 64'b100);
      idle(1);
      chk("t1_count", 64'(rec_count), 64'd1);

      // 2: sticky x, new y/z
      send(1, 32'd1); send(2, 32'd5); send(3, 0);
      chk("t2_rec", 64'(out_rec), 64'({32'd23, 1'b1, 4'h5}));
      chk("t2_mask", 64'(out_mask), 64'b011);
      idle(1);
      chk("t2_count", 64'(rec_count), 64'd2);

      // 3: backpressure holds the record and blocks input
      out_ready = 1'b0;
      send(0, 32'd9); send(3, 0);
      in_valid = 1'b1; in_sel = 0; in_data = 32'd7;
      repeat (3) begin
         @(negedge clk);
         chk("t3_blocked", 64'(in_ready), 64'd0);
         chk("t3_hold", 64'(out_rec), 64'({32'd9, 1'b1, 4'h5}));
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      send(0, 32'd7);
      chk("t3_count", 64'(rec_count), 64'd3);
      send(3, 0);
      chk("t3_rec", 64'(out_rec), 64'({32'd7, 1'b1, 4'h5}));
      chk("t3_mask", 64'(out_mask), 64'b100);
      idle(1);

      // 4: empty commit, illegal op, clear
      send(3, 0);
      chk("t4_empty_err", 64'(err), 64'd1);
      chk("t4_empty_valid", 64'(out_valid), 64'd0);
      send(9, 0);
      chk("t4_illegal_err", 64'(err), 64'd1);
      idle(1);
      chk("t4_err_pulse", 64'(err), 64'd0);
      send(1, 32'd1); send(4, 0); send(3, 0);
      chk("t4_clear_err", 64'(err), 64'd1);
      send(2, 32'd3); send(3, 0);
      chk("t4_clear_rec", 64'(out_rec), 64'({32'd0, 1'b0, 4'h3}));
      chk("t4_clear_mask", 64'(out_mask), 64'b001);
      idle(1);
      chk("t4_count", 64'(rec_count), 64'd5);

      // 5: 256 write/commit pairs at full rate wrap the counter
      t0 = cycle;
      for (int i = 0; i < 256; i++) begin
         send(0, $urandom); send(3, 0);
      end
      chk("t5_cycles", 64'(cycle - t0), 64'd512);
      idle(1);
      chk("t5_wrap", 64'(rec_count), 64'd5);

      // 6: reset while holding
      out_ready = 1'b0;
      send(0, 32'd1); send(3, 0);
      rst = 1'b1;
      idle(1);
      rst = 1'b0;
      chk("t6_valid", 64'(out_valid), 64'd0);
      chk("t6_count", 64'(rec_count), 64'd0);
      chk("t6_mask", 64'(out_mask), 64'd0);

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         int pick;
         rst       = ($urandom_range(0, 199) == 0);
         in_valid  = $urandom_range(0, 3) != 0;
         pick      = $urandom_range(0, 9);
         in_sel    = (pick < 9) ? 4'(pick % 5) : 4'($urandom_range(5, 15));
         in_data   = $urandom;
         out_ready = $urandom_range(0, 3) != 0;
         @(posedge clk); #1;
      end
      rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      idle(3);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
